// File: rtl/store_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | store_queue : circular store queue with commit tracking, dcache drain and
// |               load lookup. Define SQ_FWD_EN for store-to-load forwarding;
// |               otherwise loads stall on any older in-flight store.
// | Revision    : 1.0  initial release
// +----------------------------------------------------------------------------
module store_queue #(
  parameter int SQ_SZ = 8,
  localparam int IDXW = (SQ_SZ > 1) ? $clog2(SQ_SZ) : 1
) (
  input  logic            clock,
  input  logic            reset,
  // allocate
  input  logic            alloc_valid,
  output logic [IDXW-1:0] alloc_idx,
  output logic [IDXW-1:0] sq_tail,
  output logic            sq_full,
  // execute
  input  logic            exec_valid,
  input  logic [IDXW-1:0] exec_idx,
  input  logic [31:0]     exec_addr,
  input  logic [31:0]     exec_data,
  // lookup
  input  logic            lookup_valid,
  input  logic [31:0]     lookup_addr,
  input  logic [IDXW-1:0] lookup_sq_tail,
  output logic            forward_valid,
  output logic [31:0]     forward_data,
  output logic            forward_stall,
  // commit / drain
  input  logic            retire_valid,
  input  logic            flush,
  output logic            st_req_valid,
  output logic [31:0]     st_req_addr,
  output logic [31:0]     st_req_data,
  input  logic            st_req_ack
);

  logic [IDXW-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [IDXW:0]   count_q, count_d;
  logic [SQ_SZ-1:0] executed_q, committed_q;
  logic [31:0]     addr_q [SQ_SZ];
  logic [31:0]     data_q [SQ_SZ];

  logic            w_alloc, w_pop, w_retire, w_exec;
  logic [IDXW:0]   w_uncmt, w_cmt_cnt;
  logic [IDXW-1:0] w_exec_dist, w_older;

  assign sq_full   = (count_q == (IDXW+1)'(SQ_SZ));
  assign alloc_idx = tail_q;
  assign sq_tail   = tail_q;

  assign st_req_valid = (count_q != '0) && committed_q[head_q] && executed_q[head_q];
  assign st_req_addr  = st_req_valid ? addr_q[head_q] : 32'h0;
  assign st_req_data  = st_req_valid ? data_q[head_q] : 32'h0;

  // When full with commit_ptr==tail, the pointers alone cannot tell "all
  // committed" from "none committed"; the head entry's flag disambiguates.
  always_comb begin
    w_uncmt = {1'b0, tail_q - commit_q};
    if (sq_full && (tail_q == commit_q) && !committed_q[commit_q])
      w_uncmt = (IDXW+1)'(SQ_SZ);
  end
  assign w_cmt_cnt = count_q - w_uncmt;

  assign w_exec_dist = exec_idx - head_q;
  assign w_alloc  = alloc_valid && !sq_full && !flush;
  assign w_pop    = st_req_valid && st_req_ack;
  assign w_retire = retire_valid && !flush && (w_uncmt != '0);
  assign w_exec   = exec_valid && !flush && ({1'b0, w_exec_dist} < count_q);

  always_comb begin
    head_d   = head_q + IDXW'(w_pop);
    commit_d = commit_q + IDXW'(w_retire);
    if (flush) begin
      tail_d  = commit_q;
      count_d = w_cmt_cnt - (IDXW+1)'(w_pop);
    end else begin
      tail_d  = tail_q + IDXW'(w_alloc);
      count_d = count_q + (IDXW+1)'(w_alloc) - (IDXW+1)'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      commit_q    <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      executed_q  <= '0;
      committed_q <= '0;
      for (int i = 0; i < SQ_SZ; i++) begin
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
      end
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      if (w_alloc) begin
        executed_q[tail_q]  <= 1'b0;
        committed_q[tail_q] <= 1'b0;
      end
      if (w_exec) begin
        executed_q[exec_idx] <= 1'b1;
        addr_q[exec_idx]     <= exec_addr;
        data_q[exec_idx]     <= exec_data;
      end
      if (w_retire)
        committed_q[commit_q] <= 1'b1;
    end
  end

  assign w_older = lookup_sq_tail - head_q;

`ifdef SQ_FWD_EN
  logic            w_hit, w_stall;
  logic [31:0]     w_hit_data;
  logic [IDXW-1:0] w_slot;
  logic            w_lookup_unused;

  assign w_lookup_unused = |lookup_addr[1:0];

  // Walk oldest to youngest so the youngest deciding entry wins.
  always_comb begin
    w_hit      = 1'b0;
    w_stall    = 1'b0;
    w_hit_data = 32'h0;
    w_slot     = head_q;
    for (int d = 0; d < SQ_SZ; d++) begin
      w_slot = head_q + IDXW'(d);
      if (IDXW'(d) < w_older) begin
        if (!executed_q[w_slot]) begin
          w_stall = 1'b1;
          w_hit   = 1'b0;
        end else if (addr_q[w_slot][31:2] == lookup_addr[31:2]) begin
          w_hit      = 1'b1;
          w_stall    = 1'b0;
          w_hit_data = data_q[w_slot];
        end
      end
    end
  end

  assign forward_valid = lookup_valid && w_hit;
  assign forward_stall = lookup_valid && w_stall;
  assign forward_data  = forward_valid ? w_hit_data : 32'h0;
`else
  logic w_lookup_unused;
  assign w_lookup_unused = |lookup_addr;

  assign forward_valid = 1'b0;
  assign forward_data  = 32'h0;
  assign forward_stall = lookup_valid && (w_older != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// Directed self-checking bench for store_queue (SQ_SZ=8); expectations adapt to SQ_FWD_EN.
module tb_store_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [2:0]  alloc_idx, sq_tail;
  logic        sq_full;
  logic        exec_valid;
  logic [2:0]  exec_idx;
  logic [31:0] exec_addr, exec_data;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic [2:0]  lookup_sq_tail;
  logic        forward_valid, forward_stall;
  logic [31:0] forward_data;
  logic        retire_valid, flush;
  logic        st_req_valid;
  logic [31:0] st_req_addr, st_req_data;
  logic        st_req_ack;

  int n_tests = 0;
  int n_fail  = 0;

  store_queue #(.SQ_SZ(8)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .sq_tail(sq_tail), .sq_full(sq_full),
    .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr), .exec_data(exec_data),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_sq_tail(lookup_sq_tail),
    .forward_valid(forward_valid), .forward_data(forward_data), .forward_stall(forward_stall),
    .retire_valid(retire_valid), .flush(flush),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ack(st_req_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_exec(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    exec_valid = 1'b1; exec_idx = idx; exec_addr = a; exec_data = d;
    step();
    exec_valid = 1'b0;
  endtask

  // Lookup check: with forwarding, expect (hit, data, stall); without, stall iff older set non-empty.
  task automatic lookup(input string tag, input logic [31:0] a, input logic [2:0] lt,
                        input logic hit, input logic [31:0] d, input logic stall, input logic older);
    lookup_valid = 1'b1; lookup_addr = a; lookup_sq_tail = lt;
    #1;
`ifdef SQ_FWD_EN
    check({tag, "_fv"}, forward_valid, hit);
    check({tag, "_fd"}, forward_data, hit ? d : 32'h0);
    check({tag, "_fs"}, forward_stall, stall);
`else
    check({tag, "_fv"}, forward_valid, 1'b0);
    check({tag, "_fd"}, forward_data, 32'h0);
    check({tag, "_fs"}, forward_stall, older);
`endif
    lookup_valid = 1'b0;
  endtask

  initial begin
    alloc_valid = 0; exec_valid = 0; exec_idx = 0; exec_addr = 0; exec_data = 0;
    lookup_valid = 0; lookup_addr = 0; lookup_sq_tail = 0;
    retire_valid = 0; flush = 0; st_req_ack = 0;

    // reset overrides a simultaneous alloc
    alloc_valid = 1'b1;
    do_reset();
    alloc_valid = 1'b0;
    #1;
    check("rst_full", sq_full, 0);
    check("rst_tail", sq_tail, 0);
    check("rst_aidx", alloc_idx, 0);
    check("rst_stv", st_req_valid, 0);
    check("rst_sta", st_req_addr, 0);
    check("rst_fv", forward_valid, 0);
    check("rst_fs", forward_stall, 0);
    check("rst_fd", forward_data, 0);

    // fill the queue; the ninth request is ignored
    alloc_valid = 1'b1;
    repeat (3) step();
    check("alloc3_tail", sq_tail, 3);
    repeat (5) step();
    check("full8", sq_full, 1);
    check("full8_tail", sq_tail, 0);
    step();
    alloc_valid = 1'b0;
    check("alloc9_full", sq_full, 1);
    check("alloc9_tail", sq_tail, 0);

    // forwarding from slot 0 with a sub-word address, then stall on unexecuted slot 1
    do_exec(3'd0, 32'h100, 32'hDEAD);
    lookup("fwd0", 32'h102, 3'd1, 1'b1, 32'hDEAD, 1'b0, 1'b1);
    lookup("stall1", 32'h100, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    lookup("noolder", 32'h100, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("nolookup_fs", forward_stall, 0);
    check("nolookup_fv", forward_valid, 0);

    // retire slot 0 while full; drain held off by ack=0
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_stv", st_req_valid, 1);
      check("hold_sta", st_req_addr, 32'h100);
      step();
    end
    check("hold_std", st_req_data, 32'hDEAD);
    check("prepop_full", sq_full, 1);
    st_req_ack = 1'b1;
    step();
    st_req_ack = 1'b0;
    check("pop_full", sq_full, 0);
    check("pop_stv", st_req_valid, 0);

    // flush: 4 allocated, 1 committed; same-cycle alloc/retire ignored
    do_reset();
    alloc_valid = 1'b1;
    repeat (4) step();
    alloc_valid = 1'b0;
    do_exec(3'd0, 32'h200, 32'h1111);
    retire_valid = 1'b1;
    step();
    flush = 1'b1; alloc_valid = 1'b1;
    step();
    flush = 1'b0; retire_valid = 1'b0;
    check("flush_tail", sq_tail, 1);
    check("flush_stv", st_req_valid, 1);
    check("flush_sta", st_req_addr, 32'h200);
    repeat (6) step();
    check("flush_cnt7", sq_full, 0);
    check("flush_tail7", sq_tail, 7);
    step();
    alloc_valid = 1'b0;
    check("flush_cnt8", sq_full, 1);
    st_req_ack = 1'b1;
    step();
    st_req_ack = 1'b0;
    check("flush_drain", sq_full, 0);
    check("flush_drain_stv", st_req_valid, 0);

    // wrap: drain six stores so head=6, then look up across the wrap
    do_reset();
    alloc_valid = 1'b1;
    repeat (6) step();
    alloc_valid = 1'b0;
    for (int k = 0; k < 6; k++) do_exec(3'(k), 32'h1000 + 32'(k * 4), 32'(k));
    retire_valid = 1'b1;
    repeat (6) step();
    retire_valid = 1'b0;
    check("wrap_first_sta", st_req_addr, 32'h1000);
    st_req_ack = 1'b1;
    repeat (6) step();
    st_req_ack = 1'b0;
    check("wrap_empty_stv", st_req_valid, 0);
    check("wrap_aidx", alloc_idx, 6);
    alloc_valid = 1'b1;
    repeat (3) step();
    alloc_valid = 1'b0;
    check("wrap_tail", sq_tail, 1);
    do_exec(3'd6, 32'h300, 32'h66);
    do_exec(3'd7, 32'h400, 32'h77);
    do_exec(3'd0, 32'h400, 32'h88);
    lookup("wrap_slot0", 32'h400, 3'd1, 1'b1, 32'h88, 1'b0, 1'b1);
    lookup("wrap_slot6", 32'h300, 3'd0, 1'b1, 32'h66, 1'b0, 1'b1);
    lookup("wrap_miss", 32'h400, 3'd7, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter SQ_SZ, default 8, number of entries (power of two, at least 2); IDXW = log2(SQ_SZ).
REQ-002 SHALL have ports in this order:
  - clock  in  1  rising-edge clock.
  - reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have allocate ports:
  - alloc_valid  in  1  dispatch requests one entry.
  - alloc_idx  out  IDXW  slot granted (equals tail).
  - sq_tail  out  IDXW  current tail, recorded by loads.
  - sq_full  out  1  count==SQ_SZ.
REQ-004 SHALL have execute ports:
  - exec_valid  in  1  store address/data ready.
  - exec_idx  in  IDXW  target slot.
  - exec_addr  in  32  byte address.
  - exec_data  in  32  store word.
REQ-005 SHALL have lookup ports:
  - lookup_valid  in  1  load query.
  - lookup_addr  in  32  load address.
  - lookup_sq_tail  in  IDXW  tail at load dispatch.
  - forward_valid  out  1  data forwarded.
  - forward_data  out  32  forwarded data.
  - forward_stall  out  1  load must wait.
REQ-006 SHALL have commit/drain ports:
  - retire_valid  in  1  ROB commits oldest uncommitted store.
  - flush  in  1  discard uncommitted entries.
  - st_req_valid  out  1  dcache write request.
  - st_req_addr  out  32  write address.
  - st_req_data  out  32  write data.
  - st_req_ack  in  1  dcache accepted write.

Function
REQ-007 SHALL maintain circular pointers head, commit_ptr and tail (IDXW bits, wrap modulo SQ_SZ) plus count (IDXW+1 bits); per-entry state: executed, committed, addr, data.
REQ-008 alloc_valid && !sq_full: entry at tail cleared (executed=0, committed=0), tail+1, count+1; alloc_valid while sq_full ignored, no state change.
REQ-009 exec_valid: entry[exec_idx] gets addr/data and executed=1 at next edge; write to a free slot ignored.
REQ-010 retire_valid: entry[commit_ptr] committed=1, commit_ptr+1; ignored when commit_ptr==tail.
REQ-011 st_req_valid=1 iff count>0 and head entry committed and executed; addr/data from head, combinational; pop (head+1, count-1) at edge where st_req_valid && st_req_ack.
REQ-012 Alloc and pop in same cycle: count unchanged, both pointers advance; legal even when sq_full (pop frees, alloc still rejected that cycle).
REQ-013 flush: tail<=commit_ptr, count<=committed-entry count; committed entries and pending drain unaffected; same-cycle alloc, exec and retire ignored.
REQ-014 Lookup, combinational from registered state (same-cycle exec write not visible):
  - older set = slots at distance d from head with d < (lookup_sq_tail-head) mod SQ_SZ.
  - scan from youngest older toward head.
  - first unexecuted entry: forward_stall=1.
  - first executed entry with addr[31:2]==lookup_addr[31:2]: forward_valid=1, forward_data=its data.
  - no hit: both 0.
REQ-015 forward_valid and forward_stall SHALL never both be 1; both 0 when !lookup_valid.
REQ-016 lookup_sq_tail==head means no older stores (forward_valid=0, forward_stall=0).

Reset
REQ-017 reset at edge: head=commit_ptr=tail=0, count=0, all executed/committed=0; outputs next cycle: sq_full=0, alloc_idx=sq_tail=0, st_req_valid=0, forward_valid=0, forward_stall=0, data outputs 0.
REQ-018 reset SHALL override all simultaneous inputs, including mid-drain (outstanding request dropped).

Configuration
REQ-019 Macro SQ_FWD_EN defined: forwarding per REQ-014.
REQ-020 SQ_FWD_EN undefined: forward_valid=0, forward_data=0; forward_stall=1 whenever lookup_valid and older set non-empty.

Verification
REQ-021 Alloc 8 stores -> sq_full=1, 9th alloc_valid ignored, sq_tail=0.
REQ-022 Store slot0 exec 0x100/0xDEAD, load lookup_addr=0x102 lookup_sq_tail=1 -> forward_valid=1, forward_data=0xDEAD.
REQ-023 Slot0 executed 0x100, slot1 unexecuted, lookup 0x100 lookup_sq_tail=2 -> forward_stall=1, forward_valid=0.
REQ-024 Retire slot0, st_req_ack held 0 for 3 cycles -> st_req_valid stays 1, addr 0x100; ack=1 -> count-1 next cycle.
REQ-025 4 allocated, 1 retired, flush -> tail=1, count=1, committed entry drains.
REQ-026 Head=6 after wrap, entries 6,7,0 executed, lookup_sq_tail=1 matching slot 7 and 0 -> slot 0 data forwarded.
